// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, default operand width and the queued command entry.
//   OP_*  : ALU opcodes (F[1:0] selects AND/OR/ADD/compare, F[2] inverts B / subtracts / selects greater-than)
//   W     : default operand/result width
//   cmd_t : one queued command {a, b, f, chain}
package alu_pkg;
   localparam int W = 4;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_EQ  = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_GT  = 3'b111;
   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   f;
      logic         chain;
   } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous DEPTH-entry command FIFO.
//   clk, rst    : clock, synchronous active-high reset (pointers and level only)
//   push, pop   : write din at tail / drop head; caller never pushes when full or pops when empty
//   din, head   : tail write data, current head entry
//   level       : occupancy 0..DEPTH
//   full, empty : occupancy flags
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  cmd_t                   din,
   output cmd_t                   head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   cmd_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign head  = mem[rd_ptr];
   assign full  = level == FULL_LVL;
   assign empty = level == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // Storage is deliberately not reset.
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: buffered, flow-controlled command front-end around a combinational ALU.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready          : command handshake carrying in_a, in_b, in_f (and in_chain)
//   alu_a, alu_b, alu_f, alu_y : drive to / result from the combinational ALU
//   out_valid/out_ready, out_y : registered, back-pressured result
//   level                      : queue occupancy
// Define ALU_CMD_CHAIN_EN to add in_chain: a chained command uses the previous result as A.
module alu_cmd_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_a,
   input  logic [W-1:0]           in_b,
   input  logic [2:0]             in_f,
`ifdef ALU_CMD_CHAIN_EN
   input  logic                   in_chain,
`endif
   output logic [W-1:0]           alu_a,
   output logic [W-1:0]           alu_b,
   output logic [2:0]             alu_f,
   input  logic [W-1:0]           alu_y,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_y,
   output logic [$clog2(DEPTH):0] level
);
   cmd_t din, head;
   logic full, empty, push, issue;
   // A full queue refuses pushes even if a pop happens this cycle.
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign issue    = !empty && (!out_valid || out_ready);
   assign alu_b    = head.b;
   assign alu_f    = head.f;
`ifdef ALU_CMD_CHAIN_EN
   logic [W-1:0] prev_y;
   assign din   = '{a: in_a, b: in_b, f: in_f, chain: in_chain};
   assign alu_a = head.chain ? prev_y : head.a;
   always_ff @(posedge clk)
      if (rst) prev_y <= '0;
      else if (issue) prev_y <= alu_y;
`else
   logic unused_chain;
   assign din          = '{a: in_a, b: in_b, f: in_f, chain: 1'b0};
   assign alu_a        = head.a;
   assign unused_chain = head.chain;
`endif
   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (issue),
      .din   (din),
      .head  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_y     <= '0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_y     <= alu_y;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule
